// File: rtl/rd_fifo_ctrl_fwft.sv
// Read-side controller of the async FIFO: Gray write-pointer synchroniser, read pointer,
// RAM read issue and a 2-entry first-word-fall-through output buffer.
module rd_fifo_ctrl_fwft #(
   parameter int ADDR_WDTH   = 4,
   parameter int DATA_WDTH   = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sync_rst_n,
   input  logic [ADDR_WDTH-1:0] wr_ptr_gray,
   output logic [ADDR_WDTH-1:0] rd_ptr_gray,
   output logic [ADDR_WDTH-1:0] rd_ptr_bin,
   output logic                 mem_rd_en,
   output logic [ADDR_WDTH-1:0] mem_rd_addr,
   input  logic [DATA_WDTH-1:0] mem_rd_data,
   output logic [DATA_WDTH-1:0] dout,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic                 empty,
   output logic [ADDR_WDTH-1:0] rd_level
);

   logic [SYNC_STAGES-1:0][ADDR_WDTH-1:0] sync_q;
   logic [ADDR_WDTH-1:0]                  wr_ptr_sync;
   logic [ADDR_WDTH-1:0]                  rd_ptr;
   logic [ADDR_WDTH-1:0]                  rd_ptr_nxt;
   logic                                  inflight;
   logic [1:0]                            buf_cnt;
   logic [1:0]                            slots;
   logic [2:0]                            slots_after_pop;
   logic                                  pop;
   logic [DATA_WDTH-1:0]                  head;
   logic [DATA_WDTH-1:0]                  skid;

   // Plain flop chain; nothing may sit between stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           sync_q <= '0;
      else if (!sync_rst_n) sync_q <= '0;
      else                  sync_q <= {sync_q[SYNC_STAGES-2:0], wr_ptr_gray};
   end

   always_comb begin
      wr_ptr_sync = '0;
      wr_ptr_sync[ADDR_WDTH-1] = sync_q[SYNC_STAGES-1][ADDR_WDTH-1];
      for (int i = ADDR_WDTH-2; i >= 0; i--)
         wr_ptr_sync[i] = wr_ptr_sync[i+1] ^ sync_q[SYNC_STAGES-1][i];
   end

   assign empty    = (wr_ptr_sync == rd_ptr);
   assign rd_level = wr_ptr_sync - rd_ptr;

   // Never commit more than two words: buffered plus in flight, after this cycle's pop.
   assign pop             = dout_valid & dout_ready;
   assign slots           = buf_cnt + {1'b0, inflight};
   assign slots_after_pop = {1'b0, slots} - {2'b00, pop};
   assign mem_rd_en       = !empty && (slots_after_pop < 3'd2);
   assign rd_ptr_nxt      = rd_ptr + ADDR_WDTH'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr      <= '0;
         rd_ptr_gray <= '0;
      end else if (!sync_rst_n) begin
         rd_ptr      <= '0;
         rd_ptr_gray <= '0;
      end else if (mem_rd_en) begin
         rd_ptr      <= rd_ptr_nxt;
         rd_ptr_gray <= rd_ptr_nxt ^ (rd_ptr_nxt >> 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= 1'b0;
         buf_cnt  <= '0;
         head     <= '0;
         skid     <= '0;
      end else if (!sync_rst_n) begin
         inflight <= 1'b0;
         buf_cnt  <= '0;
         head     <= '0;
         skid     <= '0;
      end else begin
         inflight <= mem_rd_en;
         buf_cnt  <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
         if (inflight) begin
            if (buf_cnt == 2'd0 || (buf_cnt == 2'd1 && pop)) begin
               head <= mem_rd_data;
            end else if (buf_cnt == 2'd2 && pop) begin
               head <= skid;
               skid <= mem_rd_data;
            end else begin
               skid <= mem_rd_data;
            end
         end else if (pop && buf_cnt == 2'd2) begin
            head <= skid;
         end
      end
   end

   assign dout        = head;
   assign dout_valid  = (buf_cnt != 2'd0);
   assign rd_ptr_bin  = rd_ptr;
   assign mem_rd_addr = rd_ptr;

endmodule

// File: tb/tb_rd_fifo_ctrl_fwft.sv
// Bench for rd_fifo_ctrl_fwft: behavioural write side + sync-read RAM, scoreboard of written words.
module tb_rd_fifo_ctrl_fwft;

   localparam int AW = 4;
   localparam int DW = 32;

   logic          clk, rst_n, sync_rst_n;
   logic [AW-1:0] wr_ptr_gray, rd_ptr_gray, rd_ptr_bin, mem_rd_addr, rd_level;
   logic          mem_rd_en, dout_valid, dout_ready, empty;
   logic [DW-1:0] mem_rd_data, dout;

   rd_fifo_ctrl_fwft #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .sync_rst_n(sync_rst_n),
      .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray), .rd_ptr_bin(rd_ptr_bin),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .empty(empty), .rd_level(rd_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_assert = 0;
   int            n_fail   = 0;
   logic [DW-1:0] mem [16];
   logic [DW-1:0] exp_q[$];
   logic [AW-1:0] wr_ptr   = '0;
   logic [AW-1:0] exp_addr = '0;
   int            rd_cnt   = 0;
   int            wraps    = 0;
   logic          hold_prev = 1'b0;
   logic [DW-1:0] prev_dout = '0;

   function automatic logic [AW-1:0] g(input logic [AW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Synchronous-read RAM
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

   // Pointer/address tracking, FWFT stability and scoreboard pops
   always @(negedge clk) begin
      if (rst_n && sync_rst_n) begin
         chk("rd_ptr_bin", rd_ptr_bin, exp_addr);
         chk("rd_ptr_gray", rd_ptr_gray, g(exp_addr));
         if (mem_rd_en) begin
            chk("mem_rd_addr", mem_rd_addr, exp_addr);
            rd_cnt++;
            if (exp_addr == 4'hF) wraps++;
            exp_addr = exp_addr + 4'd1;
         end
         if (hold_prev && dout_valid) chk("dout_stable", dout, prev_dout);
         if (dout_valid && dout_ready) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL stale_word: observed %0h expected no word", dout);
            end
            if (exp_q.size() != 0) chk("dout_data", dout, exp_q.pop_front());
         end
         hold_prev = dout_valid && !dout_ready;
         prev_dout = dout;
      end else begin
         hold_prev = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic write_word(input logic [DW-1:0] d);
      mem[wr_ptr] = d;
      exp_q.push_back(d);
      wr_ptr      = wr_ptr + 4'd1;
      wr_ptr_gray = g(wr_ptr);
   endtask

   task automatic do_clear();
      sync_rst_n  = 1'b0;
      wr_ptr      = '0;
      wr_ptr_gray = '0;
      step();
      sync_rst_n  = 1'b1;
      exp_q.delete();
      exp_addr    = '0;
   endtask

   initial begin
      int rd0, wr0, written;
      logic done;
      rst_n = 1'b0; sync_rst_n = 1'b1; wr_ptr_gray = '0; dout_ready = 1'b1;
      repeat (3) step();
      chk("rst_dout", dout, 0);
      chk("rst_level", rd_level, 0);
      rst_n = 1'b1;

      // 1: idle after reset
      for (int i = 0; i < 20; i++) begin
         step(); @(negedge clk);
         chk("idle_empty", empty, 1);
         chk("idle_valid", dout_valid, 0);
         chk("idle_rden", mem_rd_en, 0);
      end

      // 2: single word latency
      step(); write_word(32'hA5A5_0001);
      step(); @(negedge clk); chk("lat_e1_rden", mem_rd_en, 0);
      step(); @(negedge clk); chk("lat_e2_rden", mem_rd_en, 1); chk("lat_e2_empty", empty, 0);
      step(); @(negedge clk); chk("lat_e3_valid", dout_valid, 0);
      step(); @(negedge clk); chk("lat_e4_valid", dout_valid, 1); chk("lat_e4_dout", dout, 32'hA5A5_0001);
      step(); @(negedge clk);
      chk("lat_rd_ptr", rd_ptr_bin, 1); chk("lat_gray", rd_ptr_gray, 1);
      chk("lat_empty", empty, 1); chk("lat_valid_off", dout_valid, 0);

      // 3: backpressure, then full-rate release
      step(); dout_ready = 1'b0; rd0 = rd_cnt;
      for (int i = 0; i < 5; i++) begin write_word(32'hB000_0000 + i); step(); end
      repeat (8) step();
      @(negedge clk);
      chk("bp_reads", rd_cnt - rd0, 2);
      chk("bp_level", rd_level, 3);
      chk("bp_valid", dout_valid, 1);
      chk("bp_head", dout, 32'hB000_0000);
      step(); dout_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); chk("bp_rate", dout_valid, 1);
         step();
      end
      @(negedge clk);
      chk("bp_drained", exp_q.size(), 0);
      chk("bp_valid_off", dout_valid, 0);

      // 4: wrap with random backpressure (rd_ptr starts at 6)
      step(); rd0 = rd_cnt; wr0 = wraps; written = 0; done = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (written < 40 && (wr_ptr - rd_ptr_bin) != 4'hF) begin
            write_word($urandom);
            written++;
         end
         dout_ready = 1'($urandom_range(0, 1));
         step();
         if (written == 40 && exp_q.size() == 0) begin done = 1'b1; break; end
      end
      chk("wrap_done", done, 1);
      chk("wrap_reads", rd_cnt - rd0, 40);
      chk("wrap_count", wraps - wr0, 2);

      // 6a: clear with a full output buffer
      dout_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin write_word(32'hC000_0000 + i); step(); end
      repeat (8) step();
      @(negedge clk); chk("clr_pre_valid", dout_valid, 1);
      step(); do_clear();
      @(negedge clk);
      chk("clr_valid", dout_valid, 0); chk("clr_ptr", rd_ptr_bin, 0);
      chk("clr_empty", empty, 1); chk("clr_rden", mem_rd_en, 0);
      step(); dout_ready = 1'b1;
      repeat (10) step();

      // 6b: clear while a RAM read is in flight
      write_word(32'hD000_0001); step();
      write_word(32'hD000_0002); step();
      write_word(32'hD000_0003); step();
      do_clear();
      @(negedge clk);
      chk("clr2_valid", dout_valid, 0); chk("clr2_ptr", rd_ptr_bin, 0);
      step();
      repeat (10) step();
      @(negedge clk); chk("clr2_still_idle", dout_valid, 0);

      // 5: full FIFO seen in one jump of the write pointer
      step(); dout_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin mem[i] = 32'hE000_0000 + i; exp_q.push_back(32'hE000_0000 + i); end
      wr_ptr = 4'hF; wr_ptr_gray = g(wr_ptr);
      done = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!empty) begin done = 1'b1; break; end
         step();
      end
      chk("full_seen", done, 1);
      chk("full_level", rd_level, 15);
      step(); dout_ready = 1'b1; done = 1'b0;
      for (int c = 0; c < 100; c++) begin
         step();
         if (exp_q.size() == 0) begin done = 1'b1; break; end
      end
      chk("full_drain_done", done, 1);
      repeat (3) step();
      @(negedge clk);
      chk("full_empty", empty, 1); chk("full_level0", rd_level, 0); chk("full_valid", dout_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
